// File: rtl/ibus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibus_responder_pkg
// Description : Shared types and constants for the instruction-bus responder.
//               ibus_req_t / ibus_resp_t are the fetch handshake payloads;
//               IBUS_NOP is the word returned for unmapped fetches;
//               ibus_resp_state_t encodes the responder FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package ibus_responder_pkg;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   localparam logic [31:0] IBUS_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } ibus_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/ibus_responder_imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : DEPTH_WORDS x 32 synchronous RAM, one write port and one read
//               port. A read and a write to the same index on the same edge
//               returns the word held before the write.
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_idx   - write word index
//               wr_data  - write word
//               rd_en    - read strobe (output register updates only when set)
//               rd_idx   - read word index
//               rd_data  - registered read word
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                           clk,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
   input  logic [31:0]                    wr_data,
   input  logic                           rd_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
   output logic [31:0]                    rd_data
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rd_data_q;

   // Both assignments are non-blocking, so a same-index read sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_idx];
      end
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ibus_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibus_responder
// Description : Memory-side responder for the fetch ibus handshake. Accepts a
//               request, waits LATENCY cycles, then returns addr_ok/data_ok
//               for one cycle with the instruction word read from a
//               word-addressed memory. Unmapped or misaligned fetches return
//               IBUS_NOP. A preload port writes the memory at any time.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               ireq       - fetch request (valid, addr)
//               iresp      - registered response (addr_ok, data_ok, data)
//               fault      - unmapped/misaligned flag in the response cycle
//                            (present only with IBUS_RESP_FAULT_EN defined)
//               load_en    - preload write strobe
//               load_idx   - preload word index
//               load_data  - preload word
// Options     : IBUS_RESP_FAULT_EN - adds the fault output
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_responder
   import ibus_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  ibus_req_t                      ireq,
   output ibus_resp_t                     iresp,
`ifdef IBUS_RESP_FAULT_EN
   output logic                           fault,
`endif
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
   input  logic [31:0]                    load_data
);

   localparam int          c_aw   = $clog2(DEPTH_WORDS);
   localparam logic [63:0] c_span = 64'(DEPTH_WORDS) * 64'd4;
   localparam logic [3:0]  c_lat  = 4'(LATENCY);

   ibus_resp_state_t state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [63:0]      addr_q, addr_d;
   logic             resp_q;
   logic             nomap_q;

   logic [63:0]      w_addr_eff;
   logic [63:0]      w_offset;
   logic             w_in_range;
   logic [c_aw-1:0]  w_idx;
   logic             w_rd_en;
   logic [31:0]      w_rd_data;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE: begin
            if (ireq.valid) begin
               addr_d  = ireq.addr;
               cnt_d   = c_lat;
               state_d = (c_lat == 4'd0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            // Requester withdrawing valid abandons the fetch silently.
            if (!ireq.valid) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Address decode. With zero latency the FSM goes straight from IDLE to
   // RESP before addr_q is loaded, so decode the live request address then.
   // ------------------------------------------------------------------
   assign w_addr_eff = (state_q == IDLE) ? ireq.addr : addr_q;
   assign w_offset   = w_addr_eff - BASE_ADDR;
   assign w_in_range = (w_offset < c_span) && (w_addr_eff[1:0] == 2'b00);
   assign w_idx      = w_offset[2 +: c_aw];
   assign w_rd_en    = (state_d == RESP);

   // ------------------------------------------------------------------
   // State and response flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 64'd0;
         resp_q  <= 1'b0;
         nomap_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         resp_q  <= w_rd_en;
         nomap_q <= w_rd_en && !w_in_range;
      end
   end

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_imem (
      .clk     (clk),
      .wr_en   (load_en),
      .wr_idx  (load_idx),
      .wr_data (load_data),
      .rd_en   (w_rd_en),
      .rd_idx  (w_idx),
      .rd_data (w_rd_data)
   );

   // ------------------------------------------------------------------
   // Response: built only from registers. The RAM output register is not
   // reset, so resp_q gates it to keep data at zero outside the response.
   // ------------------------------------------------------------------
   always_comb begin
      iresp         = '0;
      iresp.addr_ok = resp_q;
      iresp.data_ok = resp_q;
      if (resp_q) begin
         iresp.data = nomap_q ? IBUS_NOP : w_rd_data;
      end
   end

`ifdef IBUS_RESP_FAULT_EN
   assign fault = nomap_q;
`endif

endmodule
`default_nettype wire
